dma_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the hardware-accelerator DMA input/output paths, replacing fixed-geometry per-path FIFO instances. Configurable data width and depth, selectable standard or first-word-fall-through (FWFT) read mode, run-time programmable full/empty thresholds and an occupancy count. Sits between the DMA stream interface and the accelerator datapath, all in one clock domain.

---
 rtl/dma_sync_fifo.sv | 125 ++++++++++++
 tb/tb_dma_sync_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sync_fifo.sv
// Single-clock DMA FIFO, standard or FWFT read, programmable thresholds; optional flush_i via DMA_SYNC_FIFO_FLUSH_EN.
// Latency: read data 1 cycle after an accepted read; FWFT head visible 1 cycle after write into empty.
// Backpressure: writes when full pulse overflow_o; reads when empty pulse underflow_o; both are dropped.
module dma_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef DMA_SYNC_FIFO_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   wr_en_i,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   rd_en_i,
    input  logic [$clog2(DEPTH):0] prog_full_thresh_i,
    input  logic [$clog2(DEPTH):0] prog_empty_thresh_i,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   rd_valid_o,
    output logic                   wr_ack_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   full_o,
    output logic                   almost_full_o,
    output logic                   prog_full_o,
    output logic                   empty_o,
    output logic                   almost_empty_o,
    output logic                   prog_empty_o,
    output logic [$clog2(DEPTH):0] datacount_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         ram_cnt;
    logic                  out_vld;
    logic                  out_vld_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd;
    logic                  empty_nxt;
    logic                  flush;

`ifdef DMA_SYNC_FIFO_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // In FWFT mode count includes the word parked in the output register,
    // so the RAM itself holds count - out_vld words.
    always_comb begin
        wr_acc    = wr_en_i && !full_o;
        rd_acc    = rd_en_i && !empty_o;
        ram_cnt   = count - CW'(out_vld);
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
        if (FWFT != 0) begin
            ram_rd      = (!out_vld || rd_acc) && (ram_cnt != '0);
            out_vld_nxt = ram_rd || (out_vld && !rd_acc);
            empty_nxt   = !out_vld_nxt;
        end else begin
            ram_rd      = rd_acc;
            out_vld_nxt = 1'b0;
            empty_nxt   = (count_nxt == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !flush && !rst_i) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_vld        <= 1'b0;
            rd_valid_o     <= 1'b0;
            wr_ack_o       <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            prog_full_o    <= 1'b0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            prog_empty_o   <= 1'b1;
            // A flush keeps the last word on rdata; only reset clears it.
            if (rst_i) begin
                rdata <= '0;
            end
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_rd) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            count          <= count_nxt;
            out_vld        <= out_vld_nxt;
            rd_valid_o     <= (FWFT != 0) ? out_vld_nxt : rd_acc;
            wr_ack_o       <= wr_acc;
            overflow_o     <= wr_en_i && full_o;
            underflow_o    <= rd_en_i && empty_o;
            full_o         <= (count_nxt == CW'(DEPTH));
            almost_full_o  <= (count_nxt >= CW'(DEPTH - 1));
            prog_full_o    <= (count_nxt >= prog_full_thresh_i);
            empty_o        <= empty_nxt;
            almost_empty_o <= (count_nxt <= CW'(1));
            prog_empty_o   <= (count_nxt <= prog_empty_thresh_i);
        end
    end

    assign datacount_o = count;

endmodule

// File: tb/tb_dma_sync_fifo.sv
// Bench for dma_sync_fifo: one standard-mode and one FWFT instance checked against queue-based models.
module tb_dma_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [CW-1:0] pf_th, pe_th;
    logic          s_wr, s_rd, f_wr, f_rd;
    logic [DW-1:0] s_wd, f_wd;
    logic [DW-1:0] s_rdata, f_rdata;
    logic          s_rvld, s_ack, s_ovf, s_udf, s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty;
    logic          f_rvld, f_ack, f_ovf, f_udf, f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty;
    logic [CW-1:0] s_cnt, f_cnt;
`ifdef DMA_SYNC_FIFO_FLUSH_EN
    logic          s_flush, f_flush;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues of stored words
    logic [DW-1:0] sq[$];
    logic [DW-1:0] fq[$];
    bit            fvis;
    logic [DW-1:0] e_s_rd;
    bit            e_s_ack, e_s_ovf, e_s_udf, e_s_rv;
    bit            e_f_ack, e_f_ovf, e_f_udf;

    dma_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk_i(clk), .rst_i(rst),
`ifdef DMA_SYNC_FIFO_FLUSH_EN
        .flush_i(s_flush),
`endif
        .wr_en_i(s_wr), .wdata(s_wd), .rd_en_i(s_rd),
        .prog_full_thresh_i(pf_th), .prog_empty_thresh_i(pe_th),
        .rdata(s_rdata), .rd_valid_o(s_rvld), .wr_ack_o(s_ack), .overflow_o(s_ovf),
        .underflow_o(s_udf), .full_o(s_full), .almost_full_o(s_afull), .prog_full_o(s_pfull),
        .empty_o(s_empty), .almost_empty_o(s_aempty), .prog_empty_o(s_pempty), .datacount_o(s_cnt)
    );

    dma_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst),
`ifdef DMA_SYNC_FIFO_FLUSH_EN
        .flush_i(f_flush),
`endif
        .wr_en_i(f_wr), .wdata(f_wd), .rd_en_i(f_rd),
        .prog_full_thresh_i(pf_th), .prog_empty_thresh_i(pe_th),
        .rdata(f_rdata), .rd_valid_o(f_rvld), .wr_ack_o(f_ack), .overflow_o(f_ovf),
        .underflow_o(f_udf), .full_o(f_full), .almost_full_o(f_afull), .prog_full_o(f_pfull),
        .empty_o(f_empty), .almost_empty_o(f_aempty), .prog_empty_o(f_pempty), .datacount_o(f_cnt)
    );

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        sq.delete();
        fq.delete();
        fvis   = 1'b0;
        e_s_rd = '0;
        {e_s_ack, e_s_ovf, e_s_udf, e_s_rv, e_f_ack, e_f_ovf, e_f_udf} = '0;
        #1 rst = 1'b0;
    endtask

    // One clock: drive both instances, advance the model by the same edge, return 1 time unit after it
    task automatic cyc(input bit sw, input logic [DW-1:0] swd, input bit sr,
                       input bit fw, input logic [DW-1:0] fwd, input bit fr);
        bit sfull, semp, ffull, fempty, swok, srok, fwok, frok;
        int nb;
        s_wr = sw; s_wd = swd; s_rd = sr;
        f_wr = fw; f_wd = fwd; f_rd = fr;
        @(posedge clk);
        sfull = (sq.size() == DEPTH);
        semp  = (sq.size() == 0);
        swok  = sw && !sfull;
        srok  = sr && !semp;
        e_s_ack = swok; e_s_ovf = sw && sfull; e_s_udf = sr && semp; e_s_rv = srok;
        if (srok) e_s_rd = sq.pop_front();
        if (swok) sq.push_back(swd);
        // FWFT: a word is visible at the head one edge after it is stored
        ffull  = (fq.size() == DEPTH);
        fempty = !fvis;
        fwok   = fw && !ffull;
        frok   = fr && !fempty;
        e_f_ack = fwok; e_f_ovf = fw && ffull; e_f_udf = fr && fempty;
        nb = fq.size();
        if (frok) void'(fq.pop_front());
        fvis = (nb - int'(frok)) > 0;
        if (fwok) fq.push_back(fwd);
        #1;
        s_wr = 1'b0; s_rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    endtask

    task automatic test_reset;
        pf_th = 6'd20;
        pe_th = 6'd4;
        apply_reset(3);
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if ({s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty} !== 6'b000111) begin
            errors++; $display("FAIL reset_std_flags got %b exp 000111", {s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty});
        end
        checks++;
        if ({s_ack, s_ovf, s_udf, s_rvld} !== 4'b0000 || s_cnt !== 6'd0 || s_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_std_out pulses=%b cnt=%0d rdata=%h exp 0000/0/00", {s_ack, s_ovf, s_udf, s_rvld}, s_cnt, s_rdata);
        end
        checks++;
        if ({f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty} !== 6'b000111 || f_cnt !== 6'd0 || f_rvld !== 1'b0) begin
            errors++; $display("FAIL reset_fwft flags=%b cnt=%0d rvld=%b exp 000111/0/0", {f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty}, f_cnt, f_rvld);
        end
    endtask

    task automatic test_fill;
        int acks = 0;
        int ovfs = 0;
        for (int i = 0; i < 33; i++) begin
            cyc(1, 8'(i), 0, 0, 0, 0);
            acks += int'(s_ack);
            ovfs += int'(s_ovf);
            checks++;
            if ({s_ack, s_ovf} !== {e_s_ack, e_s_ovf}) begin
                errors++; $display("FAIL fill_pulse word %0d: ack,ovf=%b%b exp %b%b", i, s_ack, s_ovf, e_s_ack, e_s_ovf);
            end
            checks++;
            if ({s_full, s_afull, s_pfull} !== {sq.size() == DEPTH, sq.size() >= DEPTH - 1, sq.size() >= 20}) begin
                errors++; $display("FAIL fill_flags word %0d: full,afull,pfull=%b exp count %0d", i, {s_full, s_afull, s_pfull}, sq.size());
            end
            checks++;
            if (s_cnt !== CW'(i < 32 ? i + 1 : 32)) begin
                errors++; $display("FAIL fill_count word %0d: got %0d exp %0d", i, s_cnt, (i < 32 ? i + 1 : 32));
            end
        end
        checks++;
        if (acks != 32 || ovfs != 1 || s_ovf !== 1'b1) begin
            errors++; $display("FAIL fill_totals acks=%0d ovfs=%0d last_ovf=%b exp 32/1/1", acks, ovfs, s_ovf);
        end
    endtask

    task automatic test_drain_std;
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            checks++;
            if (s_rvld !== 1'b1 || s_rdata !== 8'(i)) begin
                errors++; $display("FAIL drain_data read %0d: rvld=%b rdata=%h exp 1/%h", i, s_rvld, s_rdata, 8'(i));
            end
            checks++;
            if ({s_empty, s_aempty} !== {i == 31, i >= 30} || s_cnt !== CW'(31 - i)) begin
                errors++; $display("FAIL drain_flags read %0d: empty,aempty=%b cnt=%0d exp cnt %0d", i, {s_empty, s_aempty}, s_cnt, 31 - i);
            end
        end
        cyc(0, 0, 1, 0, 0, 0);
        checks++;
        if (s_udf !== 1'b1 || s_rvld !== 1'b0 || s_rdata !== 8'h1F) begin
            errors++; $display("FAIL drain_underflow udf=%b rvld=%b rdata=%h exp 1/0/1f", s_udf, s_rvld, s_rdata);
        end
    endtask

    task automatic test_simul;
        for (int i = 0; i < 32; i++) cyc(1, 8'(8'h40 + i), 0, 1, 8'(8'h40 + i), 0);
        checks++;
        if (s_full !== 1'b1 || f_full !== 1'b1) begin
            errors++; $display("FAIL simul_full std=%b fwft=%b exp 1/1", s_full, f_full);
        end
        cyc(1, 8'hEE, 1, 1, 8'hEE, 1);
        checks++;
        if ({s_ovf, s_ack, s_rvld} !== 3'b101 || s_rdata !== 8'h40 || s_cnt !== 6'd31) begin
            errors++; $display("FAIL simul_full_std ovf,ack,rvld=%b rdata=%h cnt=%0d exp 101/40/31", {s_ovf, s_ack, s_rvld}, s_rdata, s_cnt);
        end
        checks++;
        if ({f_ovf, f_ack, f_empty} !== 3'b100 || f_rdata !== 8'h41 || f_cnt !== 6'd31) begin
            errors++; $display("FAIL simul_full_fwft ovf,ack,empty=%b rdata=%h cnt=%0d exp 100/41/31", {f_ovf, f_ack, f_empty}, f_rdata, f_cnt);
        end
        for (int i = 0; i < 31; i++) cyc(0, 0, 1, 0, 0, 1);
        cyc(1, 8'h77, 1, 1, 8'h77, 1);
        checks++;
        if ({s_udf, s_ack, s_rvld} !== 3'b110 || s_rdata !== 8'h5F || s_cnt !== 6'd1) begin
            errors++; $display("FAIL simul_empty_std udf,ack,rvld=%b rdata=%h cnt=%0d exp 110/5f/1", {s_udf, s_ack, s_rvld}, s_rdata, s_cnt);
        end
        checks++;
        if ({f_udf, f_ack, f_empty} !== 3'b111 || f_cnt !== 6'd1) begin
            errors++; $display("FAIL simul_empty_fwft udf,ack,empty=%b cnt=%0d exp 111/1", {f_udf, f_ack, f_empty}, f_cnt);
        end
        cyc(0, 0, 1, 0, 0, 0);
        checks++;
        if (s_rdata !== 8'h77 || f_empty !== 1'b0 || f_rdata !== 8'h77) begin
            errors++; $display("FAIL simul_after std_rdata=%h fwft_empty=%b fwft_rdata=%h exp 77/0/77", s_rdata, f_empty, f_rdata);
        end
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_fwft_basic;
        apply_reset(2);
        cyc(0, 0, 0, 1, 8'hA5, 0);
        checks++;
        if (f_empty !== 1'b1 || f_ack !== 1'b1 || f_cnt !== 6'd1) begin
            errors++; $display("FAIL fwft_first_edge empty=%b ack=%b cnt=%0d exp 1/1/1", f_empty, f_ack, f_cnt);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (f_empty !== 1'b0 || f_rvld !== 1'b1 || f_rdata !== 8'hA5) begin
            errors++; $display("FAIL fwft_visible empty=%b rvld=%b rdata=%h exp 0/1/a5", f_empty, f_rvld, f_rdata);
        end
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if (f_empty !== 1'b1 || f_cnt !== 6'd0 || f_rvld !== 1'b0) begin
            errors++; $display("FAIL fwft_pop empty=%b cnt=%0d rvld=%b exp 1/0/0", f_empty, f_cnt, f_rvld);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset(2);
        cyc(1, 8'd0, 0, 1, 8'd0, 0);
        cyc(1, 8'd1, 0, 1, 8'd1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(1, 8'(i + 2), 1, 1, 8'(i + 2), 1);
            checks++;
            if (s_rvld !== 1'b1 || s_rdata !== 8'(i) || s_cnt !== 6'd2) begin
                errors++; $display("FAIL b2b_std cyc %0d: rvld=%b rdata=%h cnt=%0d exp 1/%h/2", i, s_rvld, s_rdata, s_cnt, 8'(i));
            end
            checks++;
            if (f_empty !== 1'b0 || f_rdata !== 8'(i + 1) || f_cnt !== 6'd2) begin
                errors++; $display("FAIL b2b_fwft cyc %0d: empty=%b rdata=%h cnt=%0d exp 0/%h/2", i, f_empty, f_rdata, f_cnt, 8'(i + 1));
            end
        end
    endtask

    task automatic test_random;
        logic [5:0] xs, xf;
        int pw, pr;
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) begin
                pf_th = 6'($urandom_range(0, DEPTH));
                pe_th = 6'($urandom_range(0, DEPTH));
            end
            pw = (i < 300) ? 70 : 35;
            pr = (i < 300) ? 35 : 70;
            cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
            xs = {sq.size() == DEPTH, sq.size() >= DEPTH - 1, sq.size() >= int'(pf_th),
                  sq.size() == 0, sq.size() <= 1, sq.size() <= int'(pe_th)};
            xf = {fq.size() == DEPTH, fq.size() >= DEPTH - 1, fq.size() >= int'(pf_th),
                  !fvis, fq.size() <= 1, fq.size() <= int'(pe_th)};
            checks++;
            if ({s_ack, s_ovf, s_udf, s_rvld} !== {e_s_ack, e_s_ovf, e_s_udf, e_s_rv} || s_rdata !== e_s_rd) begin
                errors++; $display("FAIL rand_std_io cyc %0d: pulses=%b rdata=%h exp %b/%h", i, {s_ack, s_ovf, s_udf, s_rvld}, s_rdata, {e_s_ack, e_s_ovf, e_s_udf, e_s_rv}, e_s_rd);
            end
            checks++;
            if ({s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty} !== xs || s_cnt !== CW'(sq.size())) begin
                errors++; $display("FAIL rand_std_flags cyc %0d: flags=%b cnt=%0d exp %b/%0d", i, {s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty}, s_cnt, xs, sq.size());
            end
            checks++;
            if ({f_ack, f_ovf, f_udf, f_rvld} !== {e_f_ack, e_f_ovf, e_f_udf, fvis}) begin
                errors++; $display("FAIL rand_fwft_pulses cyc %0d: got %b exp %b", i, {f_ack, f_ovf, f_udf, f_rvld}, {e_f_ack, e_f_ovf, e_f_udf, fvis});
            end
            checks++;
            if ({f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty} !== xf || f_cnt !== CW'(fq.size())) begin
                errors++; $display("FAIL rand_fwft_flags cyc %0d: flags=%b cnt=%0d exp %b/%0d", i, {f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty}, f_cnt, xf, fq.size());
            end
            if (fvis) begin
                checks++;
                if (f_rdata !== fq[0]) begin
                    errors++; $display("FAIL rand_fwft_head cyc %0d: got %h exp %h", i, f_rdata, fq[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        pf_th = 6'd20;
        pe_th = 6'd4;
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'h90 + i), i > 2, 1, 8'(8'h90 + i), 0);
        s_wr = 1'b1; s_rd = 1'b1; f_wr = 1'b1; f_rd = 1'b1;
        apply_reset(2);
        checks++;
        if ({s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty} !== 6'b000111 || s_cnt !== 6'd0 || s_rdata !== 8'h00 || {s_ack, s_ovf, s_udf, s_rvld} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_std flags=%b cnt=%0d rdata=%h pulses=%b exp 000111/0/00/0000", {s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty}, s_cnt, s_rdata, {s_ack, s_ovf, s_udf, s_rvld});
        end
        checks++;
        if (f_empty !== 1'b1 || f_cnt !== 6'd0 || f_rvld !== 1'b0 || f_ack !== 1'b0) begin
            errors++; $display("FAIL reset_mid_fwft empty=%b cnt=%0d rvld=%b ack=%b exp 1/0/0/0", f_empty, f_cnt, f_rvld, f_ack);
        end
    endtask

`ifdef DMA_SYNC_FIFO_FLUSH_EN
    task automatic flush_cyc;
        s_flush = 1'b1; f_flush = 1'b1;
        s_wr = 1'b1; s_wd = 8'hCC; s_rd = 1'b1;
        f_wr = 1'b1; f_wd = 8'hCC; f_rd = 1'b1;
        @(posedge clk);
        sq.delete();
        fq.delete();
        fvis = 1'b0;
        #1;
        s_flush = 1'b0; f_flush = 1'b0;
        s_wr = 1'b0; s_rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    endtask

    task automatic test_flush;
        apply_reset(2);
        for (int i = 0; i < 10; i++) cyc(1, 8'(8'h20 + i), 0, 1, 8'(8'h20 + i), 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        flush_cyc();
        checks++;
        if (s_cnt !== 6'd0 || s_empty !== 1'b1 || {s_ack, s_ovf, s_udf, s_rvld} !== 4'b0000 || s_rdata !== 8'h21) begin
            errors++; $display("FAIL flush_std cnt=%0d empty=%b pulses=%b rdata=%h exp 0/1/0000/21", s_cnt, s_empty, {s_ack, s_ovf, s_udf, s_rvld}, s_rdata);
        end
        checks++;
        if (f_cnt !== 6'd0 || f_empty !== 1'b1 || f_ack !== 1'b0 || f_pempty !== 1'b1) begin
            errors++; $display("FAIL flush_fwft cnt=%0d empty=%b ack=%b pempty=%b exp 0/1/0/1", f_cnt, f_empty, f_ack, f_pempty);
        end
        cyc(1, 8'h3C, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        checks++;
        if (s_rdata !== 8'h3C || s_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_reuse rdata=%h cnt=%0d exp 3c/0", s_rdata, s_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_wr = 1'b0; s_rd = 1'b0; s_wd = '0;
        f_wr = 1'b0; f_rd = 1'b0; f_wd = '0;
        pf_th = 6'd20; pe_th = 6'd4;
`ifdef DMA_SYNC_FIFO_FLUSH_EN
        s_flush = 1'b0; f_flush = 1'b0;
`endif
        test_reset();
        test_fill();
        test_drain_std();
        test_simul();
        test_fwft_basic();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef DMA_SYNC_FIFO_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
